// File: rtl/bus_rr_scheduler.sv
// ============================================================================
// Module   : bus_rr_scheduler
// Brief    : Round-robin packet scheduler sharing one bus between FIFOs, with
//            per-destination backpressure, delivery timeout and drop counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_rr_scheduler #(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
    parameter int              TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    input  logic [DRVRS-1:0]           full,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         D_push,
    output logic [$clog2(DRVRS)-1:0]   grant_id,
    output logic                       busy,
    output logic [15:0]                drop_cnt
);

    localparam int c_GW = $clog2(DRVRS);
    localparam int c_WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARB     = 2'd1;
    localparam logic [1:0] c_DELIVER = 2'd2;
    localparam logic [1:0] c_DROP    = 2'd3;

    localparam logic [c_WW-1:0]  c_TO_LAST = c_WW'(TIMEOUT - 1);
    localparam logic [DRVRS-1:0] c_ONE     = {{(DRVRS-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_GW-1:0]    r_last_grant;
    logic [c_GW-1:0]    r_grant_id;
    logic [DRVRS-1:0]   r_mask;
    logic [c_WW-1:0]    r_wait;
    logic [15:0]        r_drop_cnt;
    logic [PCKG_SZ-1:0] r_dpush;

    logic               w_found;
    logic [c_GW-1:0]    w_next_grant;
    logic [c_GW-1:0]    w_idx;
    logic [PCKG_SZ-1:0] w_head;
    logic [ID_W-1:0]    w_id;
    logic [DRVRS-1:0]   w_gmask;
    logic [DRVRS-1:0]   w_tmask;
    logic               w_tvalid;
    logic               w_blocked;

    // Rotating search starting just after the last granted source.
    always_comb begin
        w_found      = 1'b0;
        w_next_grant = r_last_grant;
        w_idx        = '0;
        for (int k = 1; k <= DRVRS; k++) begin
            w_idx = c_GW'((int'(r_last_grant) + k) % DRVRS);
            if (!w_found && pndng[w_idx]) begin
                w_found      = 1'b1;
                w_next_grant = w_idx;
            end
        end
    end

    assign w_head  = D_pop[r_grant_id*PCKG_SZ +: PCKG_SZ];
    assign w_id    = w_head[PCKG_SZ-1 -: ID_W];
    assign w_gmask = c_ONE << r_grant_id;

    always_comb begin
        w_tmask  = '0;
        w_tvalid = 1'b0;
        if (w_id == BROADCAST) begin
            w_tmask  = ~w_gmask;
            w_tvalid = 1'b1;
        end else if ((32'(w_id) < 32'(DRVRS)) && (32'(w_id) != 32'(r_grant_id))) begin
            w_tmask  = c_ONE << w_id;
            w_tvalid = 1'b1;
        end
    end

    assign w_blocked = |(full & r_mask);

    always_comb begin
        w_state_nxt = r_state;
        pop         = '0;
        push        = '0;
        busy        = (r_state != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (w_found) w_state_nxt = c_ARB;
            end
            c_ARB: begin
                pop         = w_gmask;
                w_state_nxt = w_tvalid ? c_DELIVER : c_DROP;
            end
            c_DELIVER: begin
                // Broadcast waits until every target has room at once.
                if (!w_blocked) begin
                    push        = r_mask;
                    w_state_nxt = c_IDLE;
                end else if (r_wait == c_TO_LAST) begin
                    w_state_nxt = c_DROP;
                end
            end
            c_DROP: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_last_grant <= c_GW'(DRVRS - 1);
            r_grant_id   <= '0;
            r_mask       <= '0;
            r_wait       <= '0;
            r_drop_cnt   <= '0;
            r_dpush      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant_id   <= w_next_grant;
                        r_last_grant <= w_next_grant;
                    end
                end
                c_ARB: begin
                    r_mask <= w_tmask;
                    r_wait <= '0;
                    if (w_tvalid) r_dpush <= w_head;
                end
                c_DELIVER: begin
                    if (w_blocked) r_wait <= r_wait + c_WW'(1);
                end
                c_DROP: begin
                    if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign D_push   = r_dpush;
    assign grant_id = r_grant_id;
    assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_scheduler.sv
// ============================================================================
// Module   : tb_bus_rr_scheduler
// Brief    : Directed self-checking bench for bus_rr_scheduler (DRVRS=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_rr_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  full;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] D_push;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] drop_cnt;

    int vectors;
    int miscompares;

    logic [3:0] exp_dst [4];

    bus_rr_scheduler #(
        .DRVRS     (4),
        .PCKG_SZ   (16),
        .ID_W      (8),
        .BROADCAST (8'hFF),
        .TIMEOUT   (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .full     (full),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [15:0] val);
        D_pop[i*16 +: 16] = val;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        pndng = '0;
        full  = '0;
        D_pop = '0;
        exp_dst[0] = 4'b0010;
        exp_dst[1] = 4'b0100;
        exp_dst[2] = 4'b1000;
        exp_dst[3] = 4'b0001;

        tick; tick;
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_dpush", D_push, 0);
        reset = 1'b0;

        // Single unicast 0 -> 2
        pndng = 4'b0001;
        set_slot(0, 16'h02AB);
        #1;
        chk("t1_idle_pop", pop, 0);
        tick;
        chk("t1_arb_pop", pop, 4'b0001);
        chk("t1_arb_busy", busy, 1);
        chk("t1_arb_push", push, 0);
        pndng = 4'b0000;
        tick;
        chk("t1_dlv_push", push, 4'b0100);
        chk("t1_dlv_data", D_push, 16'h02AB);
        chk("t1_dlv_pop", pop, 0);
        tick;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_push", push, 0);
        chk("t1_hold_data", D_push, 16'h02AB);

        // Round-robin over four always-pending sources
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_slot(0, 16'h0110);
        set_slot(1, 16'h0221);
        set_slot(2, 16'h0332);
        set_slot(3, 16'h0043);
        pndng = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr_grant", grant_id, k % 4);
            chk("rr_pop", pop, 4'b0001 << (k % 4));
            tick;
            chk("rr_push", push, exp_dst[k % 4]);
            tick;
            chk("rr_idle", busy, 0);
        end
        pndng = 4'b0000;

        // Broadcast from source 1
        set_slot(1, 16'hFF5A);
        pndng = 4'b0010;
        tick;
        chk("bc_grant", grant_id, 1);
        chk("bc_pop", pop, 4'b0010);
        pndng = 4'b0000;
        tick;
        chk("bc_push", push, 4'b1101);
        chk("bc_data", D_push, 16'hFF5A);
        tick;
        pndng = 4'b0010;
        tick;
        chk("bc2_grant", grant_id, 1);
        pndng = 4'b0000;
        full  = 4'b1000;
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("bc2_blocked", push, 0);
            chk("bc2_busy", busy, 1);
            tick;
        end
        full = 4'b0000;
        #1;
        chk("bc2_push", push, 4'b1101);
        chk("bc2_data", D_push, 16'hFF5A);
        tick;
        chk("bc2_idle", busy, 0);

        // Invalid IDs: out of range, then self-addressed
        set_slot(2, 16'h0733);
        pndng = 4'b0100;
        tick;
        chk("inv1_pop", pop, 4'b0100);
        pndng = 4'b0000;
        tick;
        chk("inv1_push", push, 0);
        chk("inv1_busy", busy, 1);
        tick;
        chk("inv1_drop", drop_cnt, 1);
        set_slot(3, 16'h0399);
        pndng = 4'b1000;
        tick;
        chk("inv2_pop", pop, 4'b1000);
        pndng = 4'b0000;
        tick;
        chk("inv2_push", push, 0);
        tick;
        chk("inv2_drop", drop_cnt, 2);
        chk("inv2_idle", busy, 0);

        // Timeout on a destination held full
        set_slot(0, 16'h0211);
        set_slot(1, 16'h0322);
        full  = 4'b0100;
        pndng = 4'b0011;
        tick;
        chk("to_grant", grant_id, 0);
        pndng = 4'b0010;
        tick;
        for (int k = 0; k < 64; k++) begin
            chk("to_blocked", push, 0);
            tick;
        end
        chk("to_in_drop_busy", busy, 1);
        chk("to_in_drop_cnt", drop_cnt, 2);
        tick;
        chk("to_drop", drop_cnt, 3);
        chk("to_idle", busy, 0);
        tick;
        chk("to_next_grant", grant_id, 1);
        chk("to_next_pop", pop, 4'b0010);
        pndng = 4'b0000;
        tick;
        chk("to_next_push", push, 4'b1000);
        chk("to_next_data", D_push, 16'h0322);
        tick;

        // Reset in the middle of a blocked delivery
        set_slot(0, 16'h01CC);
        full  = 4'b0010;
        pndng = 4'b0001;
        tick;
        chk("rd_grant", grant_id, 0);
        pndng = 4'b0000;
        tick;
        chk("rd_blocked", push, 0);
        reset = 1'b1;
        #1;
        chk("rd_busy", busy, 0);
        chk("rd_pop", pop, 0);
        chk("rd_push", push, 0);
        chk("rd_drop", drop_cnt, 0);
        chk("rd_gid", grant_id, 0);
        chk("rd_dpush", D_push, 0);
        tick;
        reset = 1'b0;
        full  = 4'b0000;
        set_slot(2, 16'h0055);
        set_slot(3, 16'h0066);
        pndng = 4'b1100;
        #1;
        chk("rd_no_stale", push, 0);
        tick;
        chk("rd_first_grant", grant_id, 2);
        chk("rd_first_pop", pop, 4'b0100);
        chk("rd_arb_push", push, 0);
        pndng = 4'b1000;
        tick;
        chk("rd_push_after", push, 4'b0001);
        chk("rd_data_after", D_push, 16'h0055);
        pndng = 4'b0000;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
